// File: rtl/motor_pkg.sv
// ----------------------------------------------------------------------------
// motor_pkg: shared state encoding and default constants for motor_driver
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package motor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      FWD  = 2'b01,
      REV  = 2'b10,
      DEAD = 2'b11
   } state_t;

   localparam int c_def_pwm_period  = 256;
   localparam int c_def_cnt_w       = 8;
   localparam int c_def_dead_cycles = 64;

endpackage

`default_nettype wire

// File: rtl/motor_channel.sv
// ----------------------------------------------------------------------------
// motor_channel: one H-bridge side - input synchronizers, FSM, dead-time, drive
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module motor_channel
   import motor_pkg::*;
#(
   parameter int DEAD_CYCLES = c_def_dead_cycles
)(
   input  logic clk,
   input  logic rst,
   input  logic en_n_i,
   input  logic dir_i,
   input  logic pwm_i,
   output logic in1_o,
   output logic in2_o,
   output logic dead_o
);

   localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam logic [DW-1:0] c_dead_load = DW'(DEAD_CYCLES - 1);

   logic [1:0]    en_n_sync_q;
   logic [1:0]    dir_sync_q;
   state_t        state_q;
   logic [DW-1:0] dead_cnt_q;
   logic          in1_q;
   logic          in2_q;

   logic w_en_n;
   logic w_dir;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_n_sync_q <= '0;
         dir_sync_q  <= '0;
      end else begin
         en_n_sync_q <= {en_n_sync_q[0], en_n_i};
         dir_sync_q  <= {dir_sync_q[0], dir_i};
      end
   end

   assign w_en_n = en_n_sync_q[1];
   assign w_dir  = dir_sync_q[1];

   // Disable is tested before reversal so a simultaneous disable skips DEAD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         dead_cnt_q <= '0;
         in1_q      <= 1'b0;
         in2_q      <= 1'b0;
      end else begin
         in1_q <= (state_q == FWD) && pwm_i;
         in2_q <= (state_q == REV) && pwm_i;
         case (state_q)
            IDLE: begin
               if (!w_en_n) begin
                  state_q <= w_dir ? FWD : REV;
               end
            end
            FWD: begin
               if (w_en_n) begin
                  state_q <= IDLE;
               end else if (!w_dir) begin
                  state_q    <= DEAD;
                  dead_cnt_q <= c_dead_load;
               end
            end
            REV: begin
               if (w_en_n) begin
                  state_q <= IDLE;
               end else if (w_dir) begin
                  state_q    <= DEAD;
                  dead_cnt_q <= c_dead_load;
               end
            end
            DEAD: begin
               if (dead_cnt_q == '0) begin
                  if (w_en_n) begin
                     state_q <= IDLE;
                  end else begin
                     state_q <= w_dir ? FWD : REV;
                  end
               end else begin
                  dead_cnt_q <= dead_cnt_q - DW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in1_o  = in1_q;
   assign in2_o  = in2_q;
   assign dead_o = (state_q == DEAD);

endmodule

`default_nettype wire

// File: rtl/motor_driver.sv
// ----------------------------------------------------------------------------
// motor_driver: dual H-bridge driver with shared PWM and per-side dead-time
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module motor_driver
   import motor_pkg::*;
#(
   parameter int PWM_PERIOD  = c_def_pwm_period,
   parameter int CNT_W       = c_def_cnt_w,
   parameter int DEAD_CYCLES = c_def_dead_cycles
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             Le,
   input  logic             Re,
   input  logic             Ldir,
   input  logic             Rdir,
   input  logic [CNT_W-1:0] duty,
   output logic             l_in1,
   output logic             l_in2,
   output logic             r_in1,
   output logic             r_in2,
   output logic             busy
);

   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(PWM_PERIOD - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] duty_sh_q;
   logic             pwm_q;

   logic w_wrap;
   logic w_l_dead;
   logic w_r_dead;

   assign w_wrap = (cnt_q == c_cnt_last);
   assign cnt_d  = w_wrap ? '0 : cnt_q + CNT_W'(1);

   // Shadow reloads on the last count so a new duty applies from count 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         duty_sh_q <= '0;
         pwm_q     <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (w_wrap) begin
            duty_sh_q <= duty;
         end
         pwm_q <= (cnt_q < duty_sh_q);
      end
   end

   motor_channel #(
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_left (
      .clk    (clk),
      .rst    (reset),
      .en_n_i (Le),
      .dir_i  (Ldir),
      .pwm_i  (pwm_q),
      .in1_o  (l_in1),
      .in2_o  (l_in2),
      .dead_o (w_l_dead)
   );

   motor_channel #(
      .DEAD_CYCLES (DEAD_CYCLES)
   ) u_right (
      .clk    (clk),
      .rst    (reset),
      .en_n_i (Re),
      .dir_i  (Rdir),
      .pwm_i  (pwm_q),
      .in1_o  (r_in1),
      .in2_o  (r_in2),
      .dead_o (w_r_dead)
   );

   assign busy = w_l_dead | w_r_dead;

endmodule

`default_nettype wire

// File: tb/tb_motor_driver.sv
// ----------------------------------------------------------------------------
// tb_motor_driver: directed self-checking bench for motor_driver
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_motor_driver;

   localparam int P = 16;
   localparam int W = 5;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         Le;
   logic         Re;
   logic         Ldir;
   logic         Rdir;
   logic [W-1:0] duty;
   logic         l_in1;
   logic         l_in2;
   logic         r_in1;
   logic         r_in2;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int overlap_cnt = 0;

   always #5 clk = ~clk;

   motor_driver #(
      .PWM_PERIOD  (P),
      .CNT_W       (W),
      .DEAD_CYCLES (D)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .Le    (Le),
      .Re    (Re),
      .Ldir  (Ldir),
      .Rdir  (Rdir),
      .duty  (duty),
      .l_in1 (l_in1),
      .l_in2 (l_in2),
      .r_in1 (r_in1),
      .r_in2 (r_in2),
      .busy  (busy)
   );

   always @(negedge clk) begin
      if ((l_in1 && l_in2) || (r_in1 && r_in2)) overlap_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1; Le = 1'b1; Re = 1'b1; Ldir = 1'b1; Rdir = 1'b1; duty = '0;
      tick(3);
      checks++;
      if ({l_in1, l_in2, r_in1, r_in2, busy} !== 5'b0) begin
         errors++; $display("FAIL reset_outputs: got %b expected 00000", {l_in1, l_in2, r_in1, r_in2, busy});
      end
      Le = 1'b0; Re = 1'b0; duty = 5'd16;
      tick(5);
      checks++;
      if ({l_in1, l_in2, r_in1, r_in2, busy} !== 5'b0) begin
         errors++; $display("FAIL reset_held_active_inputs: got %b expected 00000", {l_in1, l_in2, r_in1, r_in2, busy});
      end
      Le = 1'b1; Re = 1'b1; duty = 5'd4;
      reset = 1'b0;
      tick(2);
   endtask

   task automatic test_fwd_pwm;
      int hi1, hi2, rhi;
      Ldir = 1'b1; Le = 1'b0; duty = 5'd4;
      tick(40);
      hi1 = 0; hi2 = 0; rhi = 0;
      for (int i = 0; i < 32; i++) begin
         tick(1);
         hi1 += int'(l_in1); hi2 += int'(l_in2); rhi += int'(r_in1 | r_in2);
      end
      checks++;
      if (hi1 != 8) begin errors++; $display("FAIL fwd_duty4_in1_high: got %0d expected 8", hi1); end
      checks++;
      if (hi2 != 0) begin errors++; $display("FAIL fwd_duty4_in2_high: got %0d expected 0", hi2); end
      checks++;
      if (rhi != 0) begin errors++; $display("FAIL right_idle_outputs: got %0d expected 0", rhi); end
   endtask

   task automatic test_full_duty_and_disable;
      int hi1;
      duty = 5'd16;
      tick(40);
      hi1 = 0;
      for (int i = 0; i < 32; i++) begin
         tick(1);
         hi1 += int'(l_in1);
      end
      checks++;
      if (hi1 != 32) begin errors++; $display("FAIL duty16_constant_high: got %0d expected 32", hi1); end
      Le = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         checks++;
         if (l_in1 !== 1'b1) begin errors++; $display("FAIL disable_latency_hold%0d: got %b expected 1", i, l_in1); end
      end
      tick(1);
      checks++;
      if ({l_in1, l_in2} !== 2'b00) begin errors++; $display("FAIL disable_latency_off: got %b expected 00", {l_in1, l_in2}); end
   endtask

   task automatic test_duty_zero;
      int hi, bz;
      Le = 1'b0; Ldir = 1'b1; duty = 5'd0;
      tick(40);
      hi = 0; bz = 0;
      for (int i = 0; i < 32; i++) begin
         tick(1);
         hi += int'(l_in1 | l_in2); bz += int'(busy);
      end
      checks++;
      if (hi != 0) begin errors++; $display("FAIL duty0_constant_low: got %0d expected 0", hi); end
      checks++;
      if (bz != 0) begin errors++; $display("FAIL duty0_busy: got %0d expected 0", bz); end
   endtask

   task automatic test_dead_reversal;
      int bc, rises, hi1, hi2;
      logic prev;
      duty = 5'd4; Ldir = 1'b1; Le = 1'b0;
      tick(40);
      Ldir = 1'b0;
      bc = 0; rises = 0; prev = busy;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         bc += int'(busy);
         if (busy && !prev) rises++;
         prev = busy;
      end
      checks++;
      if (bc != D) begin errors++; $display("FAIL dead_busy_cycles: got %0d expected %0d", bc, D); end
      checks++;
      if (rises != 1) begin errors++; $display("FAIL dead_busy_intervals: got %0d expected 1", rises); end
      hi1 = 0; hi2 = 0;
      for (int i = 0; i < 32; i++) begin
         tick(1);
         hi1 += int'(l_in1); hi2 += int'(l_in2);
      end
      checks++;
      if (hi2 != 8) begin errors++; $display("FAIL rev_duty4_in2_high: got %0d expected 8", hi2); end
      checks++;
      if (hi1 != 0) begin errors++; $display("FAIL rev_in1_high: got %0d expected 0", hi1); end
   endtask

   task automatic test_disable_wins;
      int bc, hi;
      Ldir = 1'b1;
      tick(30);
      Le = 1'b1; Ldir = 1'b0;
      bc = 0;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         bc += int'(busy);
      end
      checks++;
      if (bc != 0) begin errors++; $display("FAIL disable_wins_busy: got %0d expected 0", bc); end
      hi = 0;
      for (int i = 0; i < 16; i++) begin
         tick(1);
         hi += int'(l_in1 | l_in2);
      end
      checks++;
      if (hi != 0) begin errors++; $display("FAIL disable_wins_outputs: got %0d expected 0", hi); end
   endtask

   task automatic test_duty_change;
      int len;
      logic prev;
      logic found;
      Le = 1'b0; Ldir = 1'b1; duty = 5'd4;
      tick(40);
      found = 1'b0; prev = l_in1;
      for (int i = 0; i < 40 && !found; i++) begin
         tick(1);
         if (!prev && l_in1) found = 1'b1;
         prev = l_in1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL duty_change_rise1: got 0 expected 1"); end
      len = 1;
      tick(1);
      if (l_in1) len++;
      duty = 5'd8;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (!l_in1) break;
         len++;
      end
      checks++;
      if (len != 4) begin errors++; $display("FAIL duty_change_current_pulse: got %0d expected 4", len); end
      found = 1'b0; prev = l_in1;
      for (int i = 0; i < 40 && !found; i++) begin
         tick(1);
         if (!prev && l_in1) found = 1'b1;
         prev = l_in1;
      end
      len = 1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (!l_in1) break;
         len++;
      end
      checks++;
      if (!found || len != 8) begin errors++; $display("FAIL duty_change_next_pulse: got %0d expected 8 (found=%b)", len, found); end
   endtask

   task automatic test_dead_toggle;
      int bc;
      logic found;
      duty = 5'd16; Le = 1'b0; Ldir = 1'b1;
      tick(40);
      Ldir = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick(1);
         if (busy) found = 1'b1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL dead_toggle_enter: got 0 expected 1"); end
      Ldir = 1'b1;
      bc = 1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (!busy) break;
         bc++;
      end
      checks++;
      if (bc != D) begin errors++; $display("FAIL dead_toggle_length: got %0d expected %0d", bc, D); end
      tick(3);
      checks++;
      if ({l_in1, l_in2} !== 2'b10) begin errors++; $display("FAIL dead_toggle_exit_fwd: got %b expected 10", {l_in1, l_in2}); end
   endtask

   task automatic test_reset_mid;
      int hi, rhi, r1, bz;
      logic found;
      checks++;
      if (l_in1 !== 1'b1) begin errors++; $display("FAIL pre_reset_pwm_high: got %b expected 1", l_in1); end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({l_in1, l_in2, r_in1, r_in2, busy} !== 5'b0) begin errors++; $display("FAIL reset_mid_pwm: got %b expected 00000", {l_in1, l_in2, r_in1, r_in2, busy}); end
      tick(2);
      reset = 1'b0;
      duty = 5'd16; Le = 1'b0; Ldir = 1'b1;
      tick(40);
      Ldir = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick(1);
         if (busy) found = 1'b1;
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (!found || {l_in1, l_in2, r_in1, r_in2, busy} !== 5'b0) begin
         errors++; $display("FAIL reset_mid_dead: got %b expected 00000 (dead_seen=%b)", {l_in1, l_in2, r_in1, r_in2, busy}, found);
      end
      Le = 1'b1; Re = 1'b0; Rdir = 1'b0; duty = 5'd8;
      tick(2);
      reset = 1'b0;
      hi = 0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         hi += int'(r_in1 | r_in2 | l_in1 | l_in2);
      end
      checks++;
      if (hi != 0) begin errors++; $display("FAIL post_reset_early_change: got %0d expected 0", hi); end
      tick(37);
      rhi = 0; r1 = 0; bz = 0;
      for (int i = 0; i < 32; i++) begin
         tick(1);
         rhi += int'(r_in2); r1 += int'(r_in1); bz += int'(busy);
      end
      checks++;
      if (rhi != 16) begin errors++; $display("FAIL post_reset_r_in2_high: got %0d expected 16", rhi); end
      checks++;
      if (r1 != 0 || bz != 0) begin errors++; $display("FAIL post_reset_r_in1_busy: got r_in1=%0d busy=%0d expected 0 0", r1, bz); end
   endtask

   task automatic test_exclusive;
      checks++;
      if (overlap_cnt != 0) begin errors++; $display("FAIL in1_in2_overlap: got %0d expected 0", overlap_cnt); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_fwd_pwm();
      test_full_duty_and_disable();
      test_duty_zero();
      test_dead_reversal();
      test_disable_wins();
      test_duty_change();
      test_dead_toggle();
      test_reset_mid();
      test_exclusive();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/motor_driver.md
MOTOR_DRIVER -- requirements
Module: motor_driver

Interface
REQ-001 SHALL have parameter PWM_PERIOD, default 256; PWM counter period in clk cycles.
REQ-002 SHALL have parameter CNT_W, default 8; PWM counter and duty width, with 2^CNT_W >= PWM_PERIOD.
REQ-003 SHALL have parameter DEAD_CYCLES, default 64; both-off interval on direction reversal, >= 1.
REQ-004 SHALL have port: clk, input, 1; single clock, posedge.
REQ-005 SHALL have port: reset, input, 1; asynchronous, active-high.
REQ-006 SHALL have ports: Le, Re, input, 1 each; left/right motor enable, active-low (0 = run), asynchronous to clk.
REQ-007 SHALL have ports: Ldir, Rdir, input, 1 each; 1 = forward, 0 = reverse, asynchronous to clk.
REQ-008 SHALL have port: duty, input, CNT_W; PWM high time in clk cycles, common to both sides.
REQ-009 SHALL have ports: l_in1, l_in2, r_in1, r_in2, output, 1 each; H-bridge drive per side.
REQ-010 SHALL have port: busy, output, 1; high while either side is in dead-time.

Function
REQ-011 SHALL pass Le, Ldir, Re and Rdir through 2-flop synchronizers before use.
REQ-012 SHALL run one free-running PWM counter 0..PWM_PERIOD-1 that wraps to 0.
REQ-013 SHALL latch duty into a shadow register only when the counter is at PWM_PERIOD-1, so new duty takes effect from count 0.
REQ-014 SHALL drive the registered pwm bit high while counter < shadow duty: duty 0 gives constant low; duty >= PWM_PERIOD gives constant high.
REQ-015 SHALL implement per side an FSM with states IDLE, FWD, REV and DEAD.
REQ-016 IDLE SHALL go to FWD when enable = 0 and dir = 1, and to REV when enable = 0 and dir = 0.
REQ-017 FWD SHALL go to IDLE when enable = 1, else to DEAD when dir = 0; REV SHALL mirror this (IDLE on enable = 1, else DEAD on dir = 1).
REQ-018 When disable and reversal occur in the same cycle, disable SHALL win: the side goes to IDLE with no DEAD interval.
REQ-019 Entry to DEAD SHALL load a down-counter with DEAD_CYCLES-1; DEAD SHALL last exactly DEAD_CYCLES cycles.
REQ-020 At DEAD expiry the side SHALL go to IDLE if enable = 1, else to FWD or REV from dir as sampled in that cycle.
REQ-021 Further dir toggles during DEAD SHALL neither restart nor extend the interval.
REQ-022 Outputs SHALL be registered: FWD gives in1 = pwm and in2 = 0; REV gives in1 = 0 and in2 = pwm; IDLE and DEAD give both 0.
REQ-023 in1 and in2 of one side SHALL never be high in the same cycle.
REQ-024 Latency from an input edge captured at clk edge N to the corresponding output change SHALL be 3 cycles (sync N+1, state N+2, output N+3).
REQ-025 busy SHALL be high exactly while either side's state is DEAD (combinational from state).

Reset
REQ-026 While reset = 1, all outputs SHALL be 0, both FSMs IDLE, and all counters, synchronizer flops and the duty shadow 0.
REQ-027 Reset asserted mid-PWM or mid-DEAD SHALL force outputs to 0 immediately, asynchronously.
REQ-028 After reset deassertion, the first output change SHALL occur no earlier than 3 cycles later.

Structure
REQ-029 SHALL place the state encoding (IDLE = 2'b00, FWD = 2'b01, REV = 2'b10, DEAD = 2'b11) and default parameter constants in shared package motor_pkg.
REQ-030 SHALL instantiate sub-module motor_channel twice (left, right), each holding its synchronizers, FSM, dead counter and output registers; the PWM counter and duty shadow SHALL stay in the top level.

Verification (bench uses PWM_PERIOD = 16, CNT_W = 5, DEAD_CYCLES = 4)
REQ-031 Le = 0, Ldir = 1, duty = 4, settled -> l_in1 high 4 of every 16 cycles, l_in2 = 0; Le = 1 -> both 0 after 3 cycles.
REQ-032 Running FWD, Ldir 1 -> 0 -> l_in1 = l_in2 = 0 and busy = 1 for exactly 4 cycles, then l_in2 pulses at duty, never overlapping l_in1.
REQ-033 duty = 0 -> outputs constant 0; duty = 16 -> active input constant 1; duty changed 4 -> 8 mid-period -> change visible only from next count 0.
REQ-034 Same cycle Le 0 -> 1 and Ldir 1 -> 0 -> left goes to IDLE, busy stays 0.
REQ-035 reset = 1 pulsed during DEAD and during a PWM high -> all outputs 0 at once; after release with Re = 0, Rdir = 0 -> r_in2 pulses from cycle 3 on, busy = 0.
REQ-036 Ldir toggled 1 -> 0 -> 1 inside DEAD -> DEAD still 4 cycles total, exit to FWD.
